// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the codec-style I2C register-write target:
//   byte-level FSM state encoding, the codec's 7-bit device address and
//   the codec register index map.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,    // bus free, waiting for START
        ADDR,    // shifting in device address byte
        ACK_A,   // acknowledging device address
        HI,      // shifting in {REG[6:0], DATA[8]}
        ACK_H,   // acknowledging high byte
        LO,      // shifting in DATA[7:0]
        ACK_L,   // acknowledging low byte
        IGNORE   // not addressed / extra bytes: stay off the bus
    } i2cState_t;

    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;

    // Codec register indices (R15 is the reset register)
    localparam logic [6:0] R0  = 7'd0;
    localparam logic [6:0] R1  = 7'd1;
    localparam logic [6:0] R2  = 7'd2;
    localparam logic [6:0] R3  = 7'd3;
    localparam logic [6:0] R4  = 7'd4;
    localparam logic [6:0] R5  = 7'd5;
    localparam logic [6:0] R6  = 7'd6;
    localparam logic [6:0] R7  = 7'd7;
    localparam logic [6:0] R8  = 7'd8;
    localparam logic [6:0] R9  = 7'd9;
    localparam logic [6:0] R15 = 7'd15;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge
//   Brings the asynchronous SCL/SDA pad signals into the iCLK domain and
//   derives registered bus events from them.
//   Ports:
//     iCLK, iRST_N         system clock, async active-low reset
//     iI2C_SCLK, iI2C_SDAT raw SCL / SDA pad inputs
//     scl, sda             synchronized line levels (aligned with events)
//     sclRise, sclFall     one-cycle SCL edge pulses
//     start, stop          one-cycle START / STOP condition pulses
module i2c_sync_edge #(
    parameter int unsigned SYNC_LEN = 2   // 2..3
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iI2C_SCLK,
    input  logic iI2C_SDAT,
    output logic scl,
    output logic sda,
    output logic sclRise,
    output logic sclFall,
    output logic start,
    output logic stop
);

    logic [SYNC_LEN-1:0] sclSync;
    logic [SYNC_LEN-1:0] sdaSync;
    logic                sclHist;
    logic                sdaHist;
    logic                sclNow;
    logic                sdaNow;

    assign sclNow = sclSync[SYNC_LEN-1];
    assign sdaNow = sdaSync[SYNC_LEN-1];

    // Synchronizers reset to the idle-bus level (both high) so leaving
    // reset on a quiet bus cannot fabricate a START or STOP.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSync <= '1;
            sdaSync <= '1;
            sclHist <= 1'b1;
            sdaHist <= 1'b1;
            sclRise <= 1'b0;
            sclFall <= 1'b0;
            start   <= 1'b0;
            stop    <= 1'b0;
        end else begin
            sclSync <= {sclSync[SYNC_LEN-2:0], iI2C_SCLK};
            sdaSync <= {sdaSync[SYNC_LEN-2:0], iI2C_SDAT};
            sclHist <= sclNow;
            sdaHist <= sdaNow;
            sclRise <= sclNow & ~sclHist;
            sclFall <= ~sclNow & sclHist;
            // SCL must be high on both samples so an SDA change that races
            // an SCL edge is not mistaken for a bus condition.
            start   <= sclNow & sclHist &  sdaHist & ~sdaNow;
            stop    <= sclNow & sclHist & ~sdaHist &  sdaNow;
        end
    end

    // History flops hold the value that the registered events just moved to.
    assign scl = sclHist;
    assign sda = sdaHist;

endmodule

// File: rtl/i2c_codec_slave.sv
// i2c_codec_slave
//   I2C target decoding 3-byte codec register writes:
//   {SLAVE_ADDR, W}, {REG[6:0], DATA[8]}, DATA[7:0].
//   Each complete transaction produces a one-cycle oWR strobe.
//   Open-drain: SDA is only ever pulled low during ACK slots.
//   Ports:
//     iCLK, iRST_N   system clock (>= 16x SCL), async active-low reset
//     iI2C_SCLK      SCL line
//     iI2C_SDAT      SDA line as read back from the pad
//     oI2C_SDAT_OE   1 = pull SDA low
//     oWR            one-cycle register-write strobe
//     oREG_ADDR      register index, held until next oWR
//     oREG_DATA      register data, held until next oWR
//     oBUSY          high from START until STOP
module i2c_codec_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = CODEC_I2C_ADDR,
    parameter int unsigned SYNC_LEN   = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iI2C_SCLK,
    input  logic       iI2C_SDAT,
    output logic       oI2C_SDAT_OE,
    output logic       oWR,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oBUSY
);

    logic       sclLevelUnused;
    logic       sdaLvl;
    logic       sclRise;
    logic       sclFall;
    logic       startEv;
    logic       stopEv;

    i2cState_t  state;
    logic [2:0] bitCnt;
    logic       byteDone;
    logic [7:0] shiftReg;
    logic [7:0] hiByte;

    i2c_sync_edge #(
        .SYNC_LEN (SYNC_LEN)
    ) uSync (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iI2C_SCLK (iI2C_SCLK),
        .iI2C_SDAT (iI2C_SDAT),
        .scl       (sclLevelUnused),
        .sda       (sdaLvl),
        .sclRise   (sclRise),
        .sclFall   (sclFall),
        .start     (startEv),
        .stop      (stopEv)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= IDLE;
            bitCnt       <= '0;
            byteDone     <= 1'b0;
            shiftReg     <= '0;
            hiByte       <= '0;
            oI2C_SDAT_OE <= 1'b0;
            oWR          <= 1'b0;
            oREG_ADDR    <= '0;
            oREG_DATA    <= '0;
            oBUSY        <= 1'b0;
        end else begin
            oWR <= 1'b0;
            if (startEv) begin
                state        <= ADDR;
                bitCnt       <= '0;
                byteDone     <= 1'b0;
                oI2C_SDAT_OE <= 1'b0;
                oBUSY        <= 1'b1;
            end else if (stopEv) begin
                state        <= IDLE;
                bitCnt       <= '0;
                byteDone     <= 1'b0;
                oI2C_SDAT_OE <= 1'b0;
                oBUSY        <= 1'b0;
            end else begin
                case (state)
                    ADDR, HI, LO: begin
                        if (sclRise) begin
                            shiftReg <= {shiftReg[6:0], sdaLvl};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) byteDone <= 1'b1;
                        end else if (sclFall && byteDone) begin
                            // Byte complete: act on the falling edge so SDA
                            // is only touched while SCL is low.
                            byteDone <= 1'b0;
                            bitCnt   <= '0;
                            case (state)
                                ADDR: begin
                                    if (shiftReg == {SLAVE_ADDR, 1'b0}) begin
                                        state        <= ACK_A;
                                        oI2C_SDAT_OE <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                HI: begin
                                    hiByte       <= shiftReg;
                                    state        <= ACK_H;
                                    oI2C_SDAT_OE <= 1'b1;
                                end
                                default: begin
                                    state        <= ACK_L;
                                    oI2C_SDAT_OE <= 1'b1;
                                    oWR          <= 1'b1;
                                    oREG_ADDR    <= hiByte[7:1];
                                    oREG_DATA    <= {hiByte[0], shiftReg};
                                end
                            endcase
                        end
                    end
                    ACK_A, ACK_H, ACK_L: begin
                        // Release SDA on the fall that ends the 9th clock.
                        if (sclFall) begin
                            oI2C_SDAT_OE <= 1'b0;
                            bitCnt       <= '0;
                            case (state)
                                ACK_A:   state <= HI;
                                ACK_H:   state <= LO;
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    default: ; // IDLE, IGNORE: wait for START / STOP
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// tb_i2c_codec_slave
//   Directed bench: an I2C master model drives SCL/SDA (wired-AND with the
//   target's pull-down) and expected write strobes are hand-computed.
module tb_i2c_codec_slave;

    localparam int Q = 8; // quarter SCL period in iCLK cycles

    logic       iCLK;
    logic       iRST_N;
    logic       sclM;
    logic       sdaM;
    logic       sdaPad;
    logic       oI2C_SDAT_OE;
    logic       oWR;
    logic [6:0] oREG_ADDR;
    logic [8:0] oREG_DATA;
    logic       oBUSY;

    int          checkCnt = 0;
    int          errCnt   = 0;
    logic [15:0] wrQ[$];
    logic        oeSeen;

    assign sdaPad = sdaM & ~oI2C_SDAT_OE;

    i2c_codec_slave #(
        .SLAVE_ADDR (7'h1A),
        .SYNC_LEN   (2)
    ) dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iI2C_SCLK    (sclM),
        .iI2C_SDAT    (sdaPad),
        .oI2C_SDAT_OE (oI2C_SDAT_OE),
        .oWR          (oWR),
        .oREG_ADDR    (oREG_ADDR),
        .oREG_DATA    (oREG_DATA),
        .oBUSY        (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oWR) wrQ.push_back({oREG_ADDR, oREG_DATA});
        if (oI2C_SDAT_OE) oeSeen = 1'b1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepQ();
        repeat (Q) @(posedge iCLK);
    endtask

    // START or repeated START; leaves SCL low
    task automatic i2cStart();
        sdaM = 1'b1; stepQ();
        sclM = 1'b1; stepQ();
        sdaM = 1'b0; stepQ();
        sclM = 1'b0; stepQ();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; stepQ();
        sclM = 1'b1; stepQ();
        sdaM = 1'b1; stepQ();
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sdaM = b[7-i]; stepQ();
            sclM = 1'b1;   stepQ(); stepQ();
            sclM = 1'b0;   stepQ();
        end
    endtask

    // 9th clock with SDA released; ack sampled mid-high
    task automatic ackSlot(input logic expAck, input string tag);
        sdaM = 1'b1; stepQ();
        sclM = 1'b1; stepQ();
        @(negedge iCLK);
        checkVal(tag, {31'd0, ~sdaPad}, {31'd0, expAck});
        stepQ();
        sclM = 1'b0; stepQ();
    endtask

    task automatic writeByte(input logic [7:0] b, input logic expAck, input string tag);
        sendBits(b, 8);
        ackSlot(expAck, tag);
    endtask

    task automatic expectWr(input string tag, input logic [6:0] a, input logic [8:0] d);
        logic [15:0] w;
        checkVal({tag, "_present"}, {31'd0, wrQ.size() > 0}, 32'd1);
        if (wrQ.size() > 0) begin
            w = wrQ.pop_front();
            checkVal({tag, "_addr"}, {25'd0, w[15:9]}, {25'd0, a});
            checkVal({tag, "_data"}, {23'd0, w[8:0]}, {23'd0, d});
        end
    endtask

    initial begin
        iRST_N = 1'b0;
        sclM   = 1'b1;
        sdaM   = 1'b1;
        oeSeen = 1'b0;
        repeat (4) @(posedge iCLK);
        @(negedge iCLK);
        checkVal("rst_oe",   {31'd0, oI2C_SDAT_OE}, 32'd0);
        checkVal("rst_wr",   {31'd0, oWR},          32'd0);
        checkVal("rst_addr", {25'd0, oREG_ADDR},    32'd0);
        checkVal("rst_data", {23'd0, oREG_DATA},    32'd0);
        checkVal("rst_busy", {31'd0, oBUSY},        32'd0);
        iRST_N = 1'b1;
        stepQ();

        // Basic write: R2 <= 0x07B
        i2cStart();
        checkVal("t1_busy", {31'd0, oBUSY}, 32'd1);
        writeByte(8'h34, 1'b1, "t1_ack0");
        writeByte(8'h04, 1'b1, "t1_ack1");
        writeByte(8'h7B, 1'b1, "t1_ack2");
        i2cStop();
        stepQ();
        checkVal("t1_busy_end", {31'd0, oBUSY}, 32'd0);
        checkVal("t1_count", wrQ.size(), 32'd1);
        expectWr("t1", 7'h02, 9'h07B);
        checkVal("t1_hold_addr", {25'd0, oREG_ADDR}, 32'h02);

        // Back-to-back transactions
        i2cStart();
        writeByte(8'h34, 1'b1, "t2a_ack0");
        writeByte(8'h08, 1'b1, "t2a_ack1");
        writeByte(8'hF8, 1'b1, "t2a_ack2");
        i2cStop();
        i2cStart();
        writeByte(8'h34, 1'b1, "t2b_ack0");
        writeByte(8'h12, 1'b1, "t2b_ack1");
        writeByte(8'h01, 1'b1, "t2b_ack2");
        i2cStop();
        stepQ();
        checkVal("t2_count", wrQ.size(), 32'd2);
        expectWr("t2a", 7'h04, 9'h0F8);
        expectWr("t2b", 7'h09, 9'h001);

        // Wrong address, then read request: never acknowledged
        oeSeen = 1'b0;
        i2cStart();
        writeByte(8'h36, 1'b0, "t3_ack0");
        writeByte(8'h04, 1'b0, "t3_ack1");
        writeByte(8'h7B, 1'b0, "t3_ack2");
        checkVal("t3_busy", {31'd0, oBUSY}, 32'd1);
        i2cStop();
        i2cStart();
        writeByte(8'h35, 1'b0, "t4_ack0");
        writeByte(8'h04, 1'b0, "t4_ack1");
        writeByte(8'h7B, 1'b0, "t4_ack2");
        i2cStop();
        stepQ();
        checkVal("t34_oe_seen", {31'd0, oeSeen}, 32'd0);
        checkVal("t34_count", wrQ.size(), 32'd0);

        // Repeated START in the middle of the low byte
        i2cStart();
        writeByte(8'h34, 1'b1, "t5_ack0");
        writeByte(8'h0C, 1'b1, "t5_ack1");
        sendBits(8'hA0, 4);
        i2cStart();
        writeByte(8'h34, 1'b1, "t5_ack2");
        writeByte(8'h0E, 1'b1, "t5_ack3");
        writeByte(8'h01, 1'b1, "t5_ack4");
        i2cStop();
        stepQ();
        checkVal("t5_count", wrQ.size(), 32'd1);
        expectWr("t5", 7'h07, 9'h001);

        // Fourth byte is NACKed
        i2cStart();
        writeByte(8'h34, 1'b1, "t6_ack0");
        writeByte(8'h02, 1'b1, "t6_ack1");
        writeByte(8'h55, 1'b1, "t6_ack2");
        writeByte(8'hAA, 1'b0, "t6_ack3");
        i2cStop();
        stepQ();
        checkVal("t6_count", wrQ.size(), 32'd1);
        expectWr("t6", 7'h01, 9'h055);

        // Reset asserted while acknowledging the high byte
        i2cStart();
        writeByte(8'h34, 1'b1, "t7_ack0");
        sendBits(8'h04, 8);
        sdaM = 1'b1; stepQ();
        @(negedge iCLK);
        checkVal("t7_oe_before", {31'd0, oI2C_SDAT_OE}, 32'd1);
        iRST_N = 1'b0;
        #1;
        checkVal("t7_oe_async", {31'd0, oI2C_SDAT_OE}, 32'd0);
        repeat (3) @(posedge iCLK);
        iRST_N = 1'b1;
        ackSlot(1'b0, "t7_ack1");
        writeByte(8'h55, 1'b0, "t7_ack2");
        i2cStop();
        stepQ();
        checkVal("t7_count", wrQ.size(), 32'd0);
        i2cStart();
        writeByte(8'h34, 1'b1, "t8_ack0");
        writeByte(8'h1E, 1'b1, "t8_ack1");
        writeByte(8'h00, 1'b1, "t8_ack2");
        i2cStop();
        stepQ();
        checkVal("t8_count", wrQ.size(), 32'd1);
        expectWr("t8", 7'h0F, 9'h000);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/i2c_codec_slave.md
Name: i2c_codec_slave

Overview:
- I2C responder (target) for codec-style register writes: 3-byte transactions of device address, then {REG[6:0], DATA[8]}, then DATA[7:0].
- Decodes each complete transaction into a one-cycle register-write strobe carrying a 7-bit register index and 9-bit data.
- Serves two roles: bus-functional model of the audio codec for the config-master bench, and an FPGA-side I2C target on shared buses.
- Open-drain style: never drives SDA high; only asserts a pull-low enable.

Parameters:
SLAVE_ADDR, 7'h1A, 7-bit device address; the 8-bit write form is 8'h34.
SYNC_LEN, 2, number of flops in the SCL/SDA input synchronizers (range 2..3).

Ports:
iCLK  in  1  system clock; must be at least 16x the SCL frequency.
iRST_N  in  1  asynchronous, active-low reset.
iI2C_SCLK  in  1  SCL line, asynchronous to iCLK.
iI2C_SDAT  in  1  SDA line as read back from the pad, asynchronous.
oI2C_SDAT_OE  out  1  1 = pull SDA low (ACK); the pad is tri-stated otherwise.
oWR  out  1  one-cycle pulse: register write decoded.
oREG_ADDR  out  7  register index, valid while oWR=1; held until the next oWR.
oREG_DATA  out  9  register data, valid while oWR=1; held until the next oWR.
oBUSY  out  1  1 from START until STOP.

Behaviour:
- Reset values: oI2C_SDAT_OE=0, oWR=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0, state=IDLE, bit count=0.
- Reset is asynchronous: asserting it mid-ACK releases SDA in the same instant.
- Inputs pass through SYNC_LEN flops plus one history flop. Edge events are defined on the synchronized values:
  - scl_rise / scl_fall: SCL transitions.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
- START and STOP take priority over bit events in the same cycle.
- States: IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE.
- IDLE: waits for START; oBUSY=0.
- Bit sampling:
  - In ADDR, HI and LO, shift SDA MSB-first on each scl_rise; a 3-bit counter counts the bits.
  - The 8th bit completes the byte; the transition occurs on the following scl_fall.
- ADDR completion on the scl_fall after bit 8:
  - If byte[7:1]==SLAVE_ADDR and byte[0]==0: go to ACK_A and set oI2C_SDAT_OE=1 in the same cycle.
  - Otherwise (address mismatch or read request): go to IGNORE with SDA released; this is a NACK.
- ACK_x: hold OE=1 through the 9th clock. On the next scl_fall set OE=0, clear the counter, and move on: ACK_A->HI, ACK_H->LO, ACK_L->IGNORE.
- HI completion: latch the byte into a holding register; go to ACK_H.
- LO completion, on the same scl_fall that enters ACK_L:
  - Drive oWR=1 for exactly one iCLK cycle.
  - oREG_ADDR = hi[7:1].
  - oREG_DATA = {hi[0], lo[7:0]}.
- IGNORE: SDA stays released. Every byte after the third is NACKed. Exit only on START or STOP.
- START from any state (repeated START): go to ADDR, clear the counter, OE=0, oBUSY=1. A partial transaction produces no oWR.
- STOP from any state: go to IDLE, OE=0, oBUSY=0. A STOP before LO completes produces no oWR.
- The slave never stretches SCL and never drives SDA outside an ACK slot.
- Latency: oWR goes high 1 iCLK after the synchronized scl_fall following the 16th data bit, i.e. SYNC_LEN+2 iCLK cycles after the pad edge.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - CODEC_I2C_ADDR = 7'h1A;
  - codec register index constants R0..R9 and R15 (reset register).
- Sub-module i2c_sync_edge, instantiated once, contains the SYNC_LEN synchronizers for SCL/SDA plus the history flops. It outputs scl, sda, scl_rise, scl_fall, start, stop.
- The byte FSM and output registers stay in i2c_codec_slave.

Test Plan:
- START, then bytes 8'h34, 8'h04, 8'h7B, then STOP: ACK in all three slots; a single oWR with oREG_ADDR=7'h02, oREG_DATA=9'h07B; oBUSY falls on STOP.
- Back-to-back transactions 0x34/0x08/0xF8 then 0x34/0x12/0x01: two oWR pulses, (7'h04, 9'h0F8) then (7'h09, 9'h001); no spurious pulses.
- Address 8'h36, and separately read address 8'h35: SDA never pulled low in any slot; no oWR; IGNORE until STOP.
- Sequence 0x34, 0x0C, then repeated START mid-LO (after 4 bits), then 0x34/0x0E/0x01: exactly one oWR, (7'h07, 9'h001).
- Fourth byte after a valid write: NACK on the 4th slot; still only one oWR.
- iRST_N pulled low while OE=1 in ACK_H: OE=0 immediately. After release the slave ignores traffic until a fresh START; a full write then decodes correctly.
